mem_access_ctrl: RTL and testbench
==================================

MEM_ACCESS_CTRL -- requirements
Module: mem_access_ctrl

Interface
REQ-001 The block SHALL have parameter MEM_WORDS, default 32, giving the number of 32-bit words in the attached data memory; legal word index 0..MEM_WORDS-1.
REQ-002 The block SHALL have port clk, input, 1, the single clock; all state changes on its rising edge.
REQ-003 The block SHALL have port rst, input, 1, reset, asynchronous and active-high.
REQ-004 The block SHALL have port req, input, 1, pipeline access request, sampled only in IDLE.
REQ-005 The block SHALL have port we, input, 1, 1=store, 0=load.
REQ-006 The block SHALL have port size, input, 2, access size: 00 byte, 01 halfword, 10 word, 11 illegal.
REQ-007 The block SHALL have port sign_ext, input, 1, 1=sign-extend sub-word loads, 0=zero-extend.
REQ-008 The block SHALL have port addr, input, 32, byte address of the access.
REQ-009 The block SHALL have port wdata, input, 32, store data, right-aligned for sub-word stores.
REQ-010 The block SHALL have port busy, output, 1, high whenever state is not IDLE.
REQ-011 The block SHALL have port done, output, 1, one-cycle completion pulse.
REQ-012 The block SHALL have port err, output, 1, error flag, valid only while done=1.
REQ-013 The block SHALL have port rdata, output, 32, load result, held from done until next completed load.
REQ-014 The block SHALL have ports mem_addr (output, 32), mem_wdata (output, 32), mem_write (output, 1), mem_read (output, 1) driving the word-wide data memory.
REQ-015 The block SHALL have port mem_rdata, input, 32, combinational read data from the memory for the current mem_addr.

Function
REQ-016 The FSM SHALL have states IDLE, RMW_RD, ACCESS, DONE.
REQ-017 In IDLE with req=1 at a rising edge, the block SHALL latch we, size, sign_ext, addr, wdata and leave IDLE; req while busy=1 SHALL be ignored.
REQ-018 Misaligned (size=01 with addr[0]=1; size=10 with addr[1:0]!=0), size=11, or addr>>2 >= MEM_WORDS SHALL go directly to DONE with err=1 and no mem_read/mem_write pulse.
REQ-019 A legal load, or a word store, SHALL go to ACCESS; a legal sub-word store SHALL go to RMW_RD.
REQ-020 mem_addr SHALL equal {latched addr[31:2], 2'b00} in RMW_RD and ACCESS, and 0 otherwise.
REQ-021 RMW_RD SHALL assert mem_read=1 for one cycle, capture mem_rdata into a merge register at the ending edge, then go to ACCESS.
REQ-022 ACCESS SHALL assert mem_read=1 (load) or mem_write=1 (store) for exactly one cycle, then go to DONE; a load SHALL capture mem_rdata at the ending edge.
REQ-023 Store data SHALL be little-endian: byte lane addr[1:0] (byte 0 = bits 7:0), halfword lane addr[1]; untouched lanes SHALL keep merge-register contents.
REQ-024 Load extraction SHALL use the same lane mapping, extended to 32 bits per sign_ext.
REQ-025 DONE SHALL assert done=1 for exactly one cycle and return to IDLE; a new req is accepted only from IDLE, i.e. no back-to-back acceptance in the DONE cycle.
REQ-026 Latency from accepting edge to done: word/sub-word load 2 cycles, word store 2, sub-word store 3, error 1.
REQ-027 mem_read and mem_write SHALL never be high together; both SHALL be 0 in IDLE and DONE.
REQ-028 Stores SHALL leave rdata unchanged; err SHALL be 0 when done=0.

Reset
REQ-029 rst=1 SHALL immediately force IDLE, busy=0, done=0, err=0, rdata=0, mem_read=0, mem_write=0, mem_addr=0, mem_wdata=0.
REQ-030 Reset during RMW_RD or ACCESS SHALL abort the access with no memory write committed and no done pulse.

Configuration
REQ-031 Macro MEM_ACCESS_CTRL_SUBWORD_EN defined: byte/halfword accesses per REQ-018..024 supported.
REQ-032 Macro MEM_ACCESS_CTRL_SUBWORD_EN undefined: RMW_RD and lane logic SHALL be absent; size 00/01 SHALL complete via DONE with err=1 and no memory access.

Verification
REQ-033 Load word: mem word 3 = 0xDEADBEEF, req with we=0, size=10, addr=0x0C -> one mem_read pulse at mem_addr=0x0C, done 2 cycles later, rdata=0xDEADBEEF, err=0.
REQ-034 Byte store: word 1 = 0x11223344, store size=00, addr=0x06, wdata=0x000000AB -> mem_read then mem_write, mem_wdata=0x11AB3344, done 3 cycles after accept.
REQ-035 Signed halfword load: word 0 = 0x8001FFFE, size=01, addr=0x02, sign_ext=1 -> rdata=0xFFFF8001; with sign_ext=0 -> rdata=0x00008001.
REQ-036 Errors: word load addr=0x05 -> done+err next cycle, no mem pulse; word load addr=0x80 with MEM_WORDS=32 -> same.
REQ-037 Abort: assert rst during ACCESS of a word store -> mem_write drops immediately, target word unchanged, no done; req after release served normally.

Source files
------------

// File: rtl/mem_access_ctrl.sv
// mem_access_ctrl: byte/halfword/word load-store sequencer for a word-wide data memory.
// Sub-word support is enabled by defining MEM_ACCESS_CTRL_SUBWORD_EN; otherwise only word accesses succeed.
module mem_access_ctrl #(
  parameter int MEM_WORDS = 32
) (
  input  logic        clk,
  input  logic        rst,
  input  logic        req,
  input  logic        we,
  input  logic [1:0]  size,
  input  logic        sign_ext,
  input  logic [31:0] addr,
  input  logic [31:0] wdata,
  output logic        busy,
  output logic        done,
  output logic        err,
  output logic [31:0] rdata,
  output logic [31:0] mem_addr,
  output logic [31:0] mem_wdata,
  output logic        mem_write,
  output logic        mem_read,
  input  logic [31:0] mem_rdata
);
  typedef enum logic [1:0] {IDLE, RMW_RD, ACCESS, DONE} state_t;
  state_t state_q, state_d;
  logic        we_q, err_q;
  logic [31:0] addr_q, wdata_q, rdata_q;
  logic [31:0] st_word, ld_word;
  logic        accept, bad, bad_size, bad_align, bad_range, rmw;
  assign accept    = (state_q == IDLE) && req;
  assign bad_align = (size == 2'b01 && addr[0]) || (size == 2'b10 && addr[1:0] != 2'b00);
  assign bad_range = {2'b00, addr[31:2]} >= 32'(MEM_WORDS);
  assign bad       = bad_size || bad_align || bad_range;
`ifdef MEM_ACCESS_CTRL_SUBWORD_EN
  logic [1:0]  size_q;
  logic        sext_q;
  logic [31:0] merge_q;
  logic [15:0] sh;
  assign bad_size = size == 2'b11;
  assign rmw      = we && !size[1];
  // Sub-word stores overwrite only their lane of the word fetched in RMW_RD.
  always_comb begin
    st_word = wdata_q;
    if (size_q == 2'b00) begin
      st_word = merge_q;
      st_word[{addr_q[1:0], 3'b000} +: 8] = wdata_q[7:0];
    end else if (size_q == 2'b01) begin
      st_word = merge_q;
      st_word[{addr_q[1], 4'b0000} +: 16] = wdata_q[15:0];
    end
  end
  assign sh      = 16'(mem_rdata >> {addr_q[1:0], 3'b000});
  assign ld_word = size_q == 2'b00 ? {{24{sext_q & sh[7]}}, sh[7:0]} :
                   size_q == 2'b01 ? {{16{sext_q & sh[15]}}, sh[15:0]} : mem_rdata;
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      size_q  <= 2'b00;
      sext_q  <= 1'b0;
      merge_q <= '0;
    end else begin
      if (accept) begin
        size_q <= size;
        sext_q <= sign_ext;
      end
      if (state_q == RMW_RD) merge_q <= mem_rdata;
    end
`else
  logic unused_ok;
  assign bad_size  = size != 2'b10;
  assign rmw       = 1'b0;
  assign st_word   = wdata_q;
  assign ld_word   = mem_rdata;
  assign unused_ok = ^{sign_ext, addr_q[1:0]};
`endif
  always_comb begin
    state_d = state_q;
    case (state_q)
      IDLE:    state_d = !req ? IDLE : bad ? DONE : rmw ? RMW_RD : ACCESS;
      RMW_RD:  state_d = ACCESS;
      ACCESS:  state_d = DONE;
      default: state_d = IDLE;
    endcase
  end
  always_ff @(posedge clk or posedge rst)
    if (rst) begin
      state_q <= IDLE;
      we_q    <= 1'b0;
      err_q   <= 1'b0;
      addr_q  <= '0;
      wdata_q <= '0;
      rdata_q <= '0;
    end else begin
      state_q <= state_d;
      if (accept) begin
        we_q    <= we;
        err_q   <= bad;
        addr_q  <= addr;
        wdata_q <= wdata;
      end
      if (state_q == ACCESS && !we_q) rdata_q <= ld_word;
    end
  assign busy      = state_q != IDLE;
  assign done      = state_q == DONE;
  assign err       = done && err_q;
  assign rdata     = rdata_q;
  assign mem_read  = (state_q == RMW_RD) || (state_q == ACCESS && !we_q);
  assign mem_write = state_q == ACCESS && we_q;
  assign mem_addr  = (state_q == RMW_RD || state_q == ACCESS) ? {addr_q[31:2], 2'b00} : '0;
  assign mem_wdata = mem_write ? st_word : '0;
endmodule

// File: tb/tb_mem_access_ctrl.sv
// tb_mem_access_ctrl: scoreboard bench for mem_access_ctrl with a behavioural word memory.
module tb_mem_access_ctrl;
  logic        clk = 1'b0, rst = 1'b1, req = 1'b0, we = 1'b0, sign_ext = 1'b0;
  logic [1:0]  size = 2'b10;
  logic [31:0] addr = '0, wdata = '0;
  logic        busy, done, err, mem_write, mem_read;
  logic [31:0] rdata, mem_addr, mem_wdata, mem_rdata;
  logic [31:0] mem [32];
  logic        poke_en = 1'b0;
  logic [4:0]  poke_idx = '0;
  logic [31:0] poke_val = '0;
  int rd_cnt = 0, wr_cnt = 0, overlap_cnt = 0, stray_err_cnt = 0;
  logic [31:0] last_maddr = '0, last_mwdata = '0;
  int tests = 0, errors = 0;
  logic [31:0] cur_rdata = '0;
  typedef struct {
    logic [31:0] rdata;
    logic        err;
    int          lat;
    int          rd;
    int          wr;
    logic [31:0] maddr;
    logic [31:0] mwdata;
  } exp_t;
  exp_t sb [$];

  mem_access_ctrl #(.MEM_WORDS(32)) dut (
    .clk(clk), .rst(rst), .req(req), .we(we), .size(size), .sign_ext(sign_ext),
    .addr(addr), .wdata(wdata), .busy(busy), .done(done), .err(err), .rdata(rdata),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata), .mem_write(mem_write),
    .mem_read(mem_read), .mem_rdata(mem_rdata)
  );

  always #5 clk = ~clk;
  assign mem_rdata = (mem_addr[31:7] == '0) ? mem[mem_addr[6:2]] : 32'h0;

  always @(posedge clk) begin
    if (poke_en) mem[poke_idx] <= poke_val;
    if (mem_write) mem[mem_addr[6:2]] <= mem_wdata;
    if (mem_read) rd_cnt <= rd_cnt + 1;
    if (mem_write) begin
      wr_cnt <= wr_cnt + 1;
      last_mwdata <= mem_wdata;
    end
    if (mem_read || mem_write) last_maddr <= mem_addr;
    if (mem_read && mem_write) overlap_cnt <= overlap_cnt + 1;
  end
  always @(negedge clk) if (err && !done) stray_err_cnt <= stray_err_cnt + 1;

  task automatic poke(input int idx, input logic [31:0] val);
    @(negedge clk);
    poke_en = 1'b1; poke_idx = 5'(idx); poke_val = val;
    @(negedge clk);
    poke_en = 1'b0;
  endtask

  task automatic wait_idle();
    int n = 0;
    @(posedge clk); #1;
    while (busy && n < 10) begin @(posedge clk); #1; n++; end
  endtask

  task automatic access(input string name, input logic w, input logic [1:0] sz, input logic sx,
                        input logic [31:0] a, input logic [31:0] wd, input logic [31:0] ld_exp,
                        input logic ee, input int el, input int erd, input int ewr,
                        input logic [31:0] emw);
    exp_t e;
    int lat, r0, w0;
    e.rdata = (!w && !ee) ? ld_exp : cur_rdata;
    e.err = ee; e.lat = el; e.rd = erd; e.wr = ewr;
    e.maddr = {a[31:2], 2'b00}; e.mwdata = emw;
    sb.push_back(e);
    wait_idle();
    r0 = rd_cnt; w0 = wr_cnt;
    we = w; size = sz; sign_ext = sx; addr = a; wdata = wd; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0; lat = 1;
    while (!done && lat < 10) begin @(posedge clk); #1; lat++; end
    tests++;
    if (!done) begin
      errors++;
      $display("FAIL %s timeout: no done within %0d cycles", name, lat);
      void'(sb.pop_front());
      return;
    end
    e = sb.pop_front();
    cur_rdata = e.rdata;
    tests++;
    if (rdata !== e.rdata) begin errors++; $display("FAIL %s rdata got %h exp %h", name, rdata, e.rdata); end
    tests++;
    if (err !== e.err) begin errors++; $display("FAIL %s err got %b exp %b", name, err, e.err); end
    tests++;
    if (lat != e.lat) begin errors++; $display("FAIL %s latency got %0d exp %0d", name, lat, e.lat); end
    tests++;
    if (rd_cnt - r0 != e.rd || wr_cnt - w0 != e.wr) begin
      errors++;
      $display("FAIL %s pulses got rd=%0d wr=%0d exp rd=%0d wr=%0d", name, rd_cnt - r0, wr_cnt - w0, e.rd, e.wr);
    end
    if (e.rd + e.wr > 0) begin
      tests++;
      if (last_maddr !== e.maddr) begin errors++; $display("FAIL %s mem_addr got %h exp %h", name, last_maddr, e.maddr); end
    end
    if (e.wr > 0) begin
      tests++;
      if (last_mwdata !== e.mwdata) begin errors++; $display("FAIL %s mem_wdata got %h exp %h", name, last_mwdata, e.mwdata); end
    end
  endtask

  task automatic check_mem(input string name, input int idx, input logic [31:0] v);
    tests++;
    if (mem[idx] !== v) begin errors++; $display("FAIL %s mem[%0d] got %h exp %h", name, idx, mem[idx], v); end
  endtask

  task automatic test_reset();
    for (int i = 0; i < 32; i++) poke(i, 32'h0);
    tests++;
    if ({busy, done, err, mem_read, mem_write} !== 5'b0 || rdata !== '0 || mem_addr !== '0 || mem_wdata !== '0) begin
      errors++;
      $display("FAIL reset outputs got busy=%b done=%b err=%b rd=%b wr=%b rdata=%h maddr=%h mwdata=%h exp all zero",
               busy, done, err, mem_read, mem_write, rdata, mem_addr, mem_wdata);
    end
    @(negedge clk); rst = 1'b0;
  endtask

  task automatic test_word();
    poke(3, 32'hDEADBEEF);
    access("load_word", 0, 2'b10, 0, 32'h0C, 0, 32'hDEADBEEF, 0, 2, 1, 0, 0);
    access("store_word", 1, 2'b10, 0, 32'h10, 32'hCAFEF00D, 0, 0, 2, 0, 1, 32'hCAFEF00D);
    check_mem("store_word", 4, 32'hCAFEF00D);
    access("load_back", 0, 2'b10, 0, 32'h10, 0, 32'hCAFEF00D, 0, 2, 1, 0, 0);
  endtask

  task automatic test_subword();
    poke(1, 32'h11223344);
    poke(0, 32'h8001FFFE);
    poke(5, 32'hAAAABBBB);
`ifdef MEM_ACCESS_CTRL_SUBWORD_EN
    access("store_byte", 1, 2'b00, 0, 32'h06, 32'h000000AB, 0, 0, 3, 1, 1, 32'h11AB3344);
    check_mem("store_byte", 1, 32'h11AB3344);
    access("load_half_s", 0, 2'b01, 1, 32'h02, 0, 32'hFFFF8001, 0, 2, 1, 0, 0);
    access("load_half_u", 0, 2'b01, 0, 32'h02, 0, 32'h00008001, 0, 2, 1, 0, 0);
    access("load_byte_s", 0, 2'b00, 1, 32'h01, 0, 32'hFFFFFFFF, 0, 2, 1, 0, 0);
    access("load_byte_u", 0, 2'b00, 0, 32'h00, 0, 32'h000000FE, 0, 2, 1, 0, 0);
    access("store_half", 1, 2'b01, 0, 32'h16, 32'h00001234, 0, 0, 3, 1, 1, 32'h1234BBBB);
    check_mem("store_half", 5, 32'h1234BBBB);
`else
    access("store_byte_off", 1, 2'b00, 0, 32'h06, 32'h000000AB, 0, 1, 1, 0, 0, 0);
    check_mem("store_byte_off", 1, 32'h11223344);
    access("load_half_off", 0, 2'b01, 1, 32'h02, 0, 0, 1, 1, 0, 0, 0);
`endif
  endtask

  task automatic test_errors();
    poke(8, 32'h55555555);
    access("err_misalign_w", 0, 2'b10, 0, 32'h05, 0, 0, 1, 1, 0, 0, 0);
    access("err_range", 0, 2'b10, 0, 32'h80, 0, 0, 1, 1, 0, 0, 0);
    access("err_misalign_h", 0, 2'b01, 0, 32'h03, 0, 0, 1, 1, 0, 0, 0);
    access("err_size11", 0, 2'b11, 0, 32'h00, 0, 0, 1, 1, 0, 0, 0);
    access("err_store", 1, 2'b10, 0, 32'h22, 32'hFFFFFFFF, 0, 1, 1, 0, 0, 0);
    check_mem("err_store", 8, 32'h55555555);
  endtask

  task automatic test_back_to_back();
    int n = 0;
    wait_idle();
    we = 0; size = 2'b10; sign_ext = 0; addr = 32'h0C; req = 1'b1;
    @(posedge clk); #1;
    while (!done && n < 10) begin @(posedge clk); #1; n++; end
    tests++;
    if (!done) begin errors++; $display("FAIL b2b first done missing"); end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b0) begin errors++; $display("FAIL b2b accept_in_done busy got %b exp 0", busy); end
    @(posedge clk); #1;
    tests++;
    if (busy !== 1'b1) begin errors++; $display("FAIL b2b accept_in_idle busy got %b exp 1", busy); end
    req = 1'b0; n = 0;
    while (!done && n < 10) begin @(posedge clk); #1; n++; end
    tests++;
    if (!done || rdata !== 32'hDEADBEEF) begin
      errors++;
      $display("FAIL b2b second done=%b rdata got %h exp DEADBEEF", done, rdata);
    end
    cur_rdata = 32'hDEADBEEF;
  endtask

  task automatic test_abort();
    int seen = 0;
    wait_idle();
    we = 1; size = 2'b10; addr = 32'h20; wdata = 32'h12345678; req = 1'b1;
    @(posedge clk); #1;
    req = 1'b0;
    tests++;
    if (mem_write !== 1'b1) begin errors++; $display("FAIL abort pre mem_write got %b exp 1", mem_write); end
    rst = 1'b1; #1;
    tests++;
    if (mem_write !== 1'b0 || done !== 1'b0 || busy !== 1'b0) begin
      errors++;
      $display("FAIL abort during_rst got wr=%b done=%b busy=%b exp 0 0 0", mem_write, done, busy);
    end
    @(posedge clk); #1;
    @(negedge clk); rst = 1'b0;
    for (int i = 0; i < 3; i++) begin @(posedge clk); #1; if (done) seen++; end
    tests++;
    if (seen != 0) begin errors++; $display("FAIL abort done_after got %0d pulses exp 0", seen); end
    check_mem("abort", 8, 32'h55555555);
    cur_rdata = '0;
    access("after_abort", 0, 2'b10, 0, 32'h20, 0, 32'h55555555, 0, 2, 1, 0, 0);
  endtask

  initial begin
    test_reset();
    test_word();
    test_subword();
    test_errors();
    test_back_to_back();
    test_abort();
    tests++;
    if (overlap_cnt != 0 || stray_err_cnt != 0) begin
      errors++;
      $display("FAIL invariants got overlap=%0d stray_err=%0d exp 0 0", overlap_cnt, stray_err_cnt);
    end
    $display("[TB] %0d tests run, %0d failed", tests, errors);
    $finish;
  end
endmodule
